// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier, one multiplier bit per cycle.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin a multiplication (accepted only in IDLE)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   operand_a    multiplicand, W bits
//   operand_b    multiplier, W bits
//   result       registered 2W-bit product, updated only on entry to FINISH
//   busy         high in RUN and FINISH
//   done         one-cycle pulse in FINISH
//
// Signed operands are reduced to magnitudes at capture and the product is
// negated at the end when the operand signs differ. The magnitude of the most
// negative value fits because the magnitude register is treated as unsigned.
//
// state  | meaning
// IDLE   | waiting for start; result holds last product
// RUN    | W iterations, one multiplier bit per cycle (LSB first)
// FINISH | result valid, done pulse, back to IDLE next edge
module seq_multiplier #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   operand_a,
  input  logic [W-1:0]   operand_b,
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_FINISH = 2'b10;

  logic [1:0]     state_q,  state_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic [2*W-1:0] mcand_q,  mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic           neg_q,    neg_d;
  logic [2*W-1:0] acc_q,    acc_d;
  logic [2*W-1:0] result_q, result_d;

  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] sum;

  always_comb begin
    mag_a = (signed_mode && operand_a[W-1]) ? -operand_a : operand_a;
    mag_b = (signed_mode && operand_b[W-1]) ? -operand_b : operand_b;
    sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          mcand_d  = {{W{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = signed_mode & (operand_a[W-1] ^ operand_b[W-1]);
          acc_d    = '0;
          cnt_d    = CW'(W);
        end
      end
      S_RUN: begin
        acc_d    = sum;
        mcand_d  = {mcand_q[2*W-2:0], 1'b0};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last iteration: publish the finished product in the same edge so the
        // accumulator's partial values never reach result. Negating zero is
        // zero, so a zero product is always +0.
        if (cnt_q == CW'(1)) begin
          state_d  = S_FINISH;
          result_d = neg_q ? -sum : sum;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q == S_RUN) || (state_q == S_FINISH);
  assign done   = (state_q == S_FINISH);

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   operand_a;
  logic [W-1:0]   operand_b;
  logic [2*W-1:0] result;
  logic           busy;
  logic           done;

  seq_multiplier #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .result      (result),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_done = -1;
  bit stream_on = 1'b0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int x;
    int y;
    int p;
    x = sm ? int'($signed(a)) : int'(a);
    y = sm ? int'($signed(b)) : int'(b);
    p = x * y;
    return p[15:0];
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: every done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done got_result=%0h", result);
      end else begin
        chk("sb_result", 32'(result), 32'(exp_q.pop_front()));
      end
      if (stream_on && last_done >= 0) chk("stream_period", cyc - last_done, 10);
      last_done = cyc;
    end
  end

  // One isolated operation: checks done latency, busy span and result hold.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp, input string name);
    int k_done;
    int busy_bad;
    k_done = -1;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1; operand_a = a; operand_b = b; signed_mode = sm;
    exp_q.push_back(exp);
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; operand_a = ~a; operand_b = ~b; signed_mode = ~sm;
      end
      if (done === 1'b1 && k_done < 0) k_done = k;
      if (busy !== (k <= 9)) busy_bad++;
    end
    chk({name, "_latency"}, k_done, 9);
    chk({name, "_busy_span"}, busy_bad, 0);
    chk({name, "_hold"}, 32'(result), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    int d0;
    int t;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255"};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000, "s_m128sq"};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 16'h4000, "u128sq"};
    vecs[3] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5"};
    vecs[4] = '{8'h00, 8'hF9, 1'b1, 16'h0000, "s_0xm7"};
    vecs[5] = '{8'h7F, 8'h80, 1'b1, 16'hC080, "s_127xm128"};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1xm1"};
    vecs[7] = '{8'h80, 8'h01, 1'b1, 16'hFF80, "s_m128x1"};
    vecs[8] = '{8'h0C, 8'h0A, 1'b0, 16'h0078, "u12x10"};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; operand_a = '0; operand_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_result", 32'(result), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, vecs[i].name);

    // start re-asserted and operands changed while busy
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; operand_a = 8'd12; operand_b = 8'd10; signed_mode = 1'b0;
    exp_q.push_back(16'h0078);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b1; operand_a = 8'(8'd33 + c); operand_b = 8'h44; signed_mode = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ignore_start_one_done", done_cnt - d0, 1);
    chk("ignore_start_result", 32'(result), 32'h0078);

    // reset in RUN cycle 4
    @(negedge clk);
    start = 1'b1; operand_a = 8'd200; operand_b = 8'd3; signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    do_op(8'd7, 8'd6, 1'b0, 16'd42, "after_abort_7x6");

    // start held high: back-to-back stream
    stream_on = 1'b1;
    last_done = -1;
    d0 = done_cnt;
    @(negedge clk);
    ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); rs = 1'($urandom_range(0, 1));
    start = 1'b1; operand_a = ra; operand_b = rb; signed_mode = rs;
    exp_q.push_back(ref_mul(ra, rb, rs));
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 999) begin
        ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); rs = 1'($urandom_range(0, 1));
        operand_a = ra; operand_b = rb; signed_mode = rs;
        exp_q.push_back(ref_mul(ra, rb, rs));
      end else begin
        start = 1'b0;
      end
      if (i < 999) repeat (9) @(posedge clk);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    stream_on = 1'b0;
    chk("stream_done_count", done_cnt - d0, 1000);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Parameters
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits; legal range is 2..32.

Interface
REQ-002 The block SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have start, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-006 The block SHALL have operand_a, input, W bits: multiplicand.
REQ-007 The block SHALL have operand_b, input, W bits: multiplier.
REQ-008 The block SHALL have result, output, 2W bits: registered product.
REQ-009 The block SHALL have busy, output, 1 bit: high while a multiplication is in progress.
REQ-010 The block SHALL have done, output, 1 bit: single-cycle pulse marking result valid.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, RUN and FINISH; any unused encoding SHALL return to IDLE on the next edge.
REQ-012 In IDLE with start=1, the block SHALL capture operand_a, operand_b and signed_mode on that edge, clear the accumulator, load the iteration counter with W and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE and SHALL leave result unchanged.
REQ-014 RUN SHALL last exactly W cycles; each cycle SHALL test one multiplier bit (LSB first), add the shifted multiplicand magnitude when that bit is 1, and decrement the counter.
REQ-015 The FSM SHALL leave RUN when the counter reaches 0, SHALL enter FINISH, and SHALL write result on that edge.
REQ-016 FINISH SHALL last one cycle with done=1 and SHALL then return to IDLE.
REQ-017 The done pulse SHALL therefore occur in the (W+1)th cycle after the edge that accepted start; for W=8, done is high in cycle 9.
REQ-018 busy SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-019 done SHALL be 1 only in FINISH.
REQ-020 start SHALL be ignored while busy=1; captured operands SHALL be immune to input changes after acceptance.
REQ-021 start=1 during the FINISH cycle SHALL be ignored; start held high SHALL be accepted on the first IDLE edge after FINISH, giving back-to-back operations every W+2 cycles.
REQ-022 Unsigned mode SHALL produce the exact 2W-bit product, zero-extended operands, no overflow possible.
REQ-023 Signed mode SHALL multiply operand magnitudes and SHALL two's-complement negate the 2W-bit product when the operand signs differ.
REQ-024 In signed mode, a zero product SHALL be +0 regardless of operand signs.
REQ-025 In signed mode, the magnitude of -2^(W-1) SHALL be handled as the W-bit unsigned value 2^(W-1) without overflow.
REQ-026 result SHALL hold its value from FINISH until the next FINISH.
REQ-027 Intermediate accumulator values SHALL never appear on result.

Reset
REQ-028 While rst=1, the block SHALL immediately, without waiting for clk, set state=IDLE, result=0, busy=0, done=0, and clear the counter, accumulator and captured operands.
REQ-029 Reset asserted mid-RUN or in FINISH SHALL abort the operation; no done pulse SHALL follow.
REQ-030 The first start accepted after reset deassertion SHALL behave as a normal operation.

Verification (W=8)
REQ-031 The bench SHALL run unsigned 255 x 255 and SHALL see result=0xFE01 with done exactly 9 cycles after start acceptance and busy high for 9 cycles.
REQ-032 The bench SHALL run signed -128 x -128 (0x80 x 0x80) and SHALL see result=0x4000; the same operands unsigned SHALL give 0x4000.
REQ-033 The bench SHALL run signed -3 x 5 (0xFD x 0x05) and SHALL see result=0xFFF1; signed 0 x -7 SHALL give 0x0000.
REQ-034 The bench SHALL start 12 x 10, then in cycles 2-5 assert start with different operands and change operand_a; it SHALL see result=120 (0x0078) and exactly one done pulse.
REQ-035 The bench SHALL assert rst in RUN cycle 4 of 200 x 3; it SHALL see immediate busy=0, done=0, result=0 and no done afterward, and a following 7 x 6 SHALL give 42.
REQ-036 The bench SHALL hold start high continuously with a stream of operands; it SHALL see a done pulse every 10 cycles, each result matching a reference model over 1000 random signed/unsigned pairs.
